spw_link_status_collector: RTL and testbench
============================================

// Module: spw_link_status_collector
// PURPOSE
//  Builds the 16-bit SpaceWire link status word driven into the link-status PIO input port.
//  Sits between the SpaceWire codec (link FSM state, error pulses) and the read-only status PIO.
//  Adds a debounced link-up flag, sticky error flags, saturating counters and a change strobe.
//  Software clears sticky state via a clear pulse from a separate control register.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  consecutive cycles in RUN before link_up asserts (legal range 1..255)
//  CNT_W            4   width of each saturating counter (fixed by word map; do not change)
// PORTS
//  clk             in   1   system clock; all logic on rising edge
//  reset_n         in   1   synchronous, active-low reset
//  link_state      in   3   codec FSM: 0 ErrorReset,1 ErrorWait,2 Ready,3 Started,4 Connecting,5 Run
//  err_disconnect  in   1   1-cycle pulse, disconnect error
//  err_parity      in   1   1-cycle pulse, parity error
//  err_escape      in   1   1-cycle pulse, escape error
//  err_credit      in   1   1-cycle pulse, credit error
//  tc_valid        in   1   1-cycle pulse, time-code received (used only with macro)
//  tc_value        in   6   received time-code value
//  clear_req       in   1   1-cycle pulse, clears sticky flags and counters
//  status_word     out  16  registered status word to PIO input port
//  status_changed  out  1   1-cycle pulse when status_word changes value
// BEHAVIOUR
//  Reset (reset_n low at clk edge): all registers 0; status_word=16'h0000, status_changed=0.
//  Word map: [2:0] link_state (registered copy), [3] link_up, [4] disconnect, [5] parity,
//   [6] escape, [7] credit sticky flags, [11:8] err_cnt, [15:12] down_cnt (or time-code, see CONFIG).
//  Latency: any input affects status_word exactly 1 cycle later; status_changed 1 cycle after that.
//  Values of link_state >5 are passed through unchanged; only 5 counts as Run.
//  Debounce FSM: DOWN -> QUAL on link_state==5; QUAL counts cycles; QUAL -> UP when count reaches
//   DEBOUNCE_CYCLES; any non-5 state in QUAL or UP -> DOWN next cycle. link_up=1 only in UP.
//  down_cnt: +1 on each UP->DOWN transition, saturates at 15.
//  Sticky flag: set on its pulse, held until clear_req or reset.
//  err_cnt: += popcount(4 error pulses) per cycle, saturates at 15 (no wrap).
//  clear_req with simultaneous error pulses: clear applied first, then the pulses -> flags set,
//   err_cnt = popcount of that cycle. clear_req does not affect link_state/link_up/FSM.
//  clear_req in same cycle as UP->DOWN: down_cnt = 1.
//  status_changed: compares new status_word with previous; pulses once per differing cycle;
//   held 0 on the first cycle after reset release.
//  Reset mid-qualification: FSM returns to DOWN, qualification count restarts from 0.
// CONFIGURATION
//  SPW_LINK_TC_CAPTURE_EN defined: [15:12] = tc_value[3:0] of last tc_valid, captured the cycle
//   tc_valid is high; not affected by clear_req; down_cnt logic is not instantiated.
//  Not defined: [15:12] = down_cnt; tc_valid/tc_value ignored (ports remain present).
// STRUCTURE
//  Package spw_link_status_pkg: link state encoding constants, RUN value, word bit positions
//   and field widths, debounce FSM state enum.
//  Sub-module spw_sat_counter (width, increment input, clear, saturate at all-ones), used for
//   err_cnt and down_cnt.
// TESTING
//  Reset then hold link_state=5 for 16 cycles -> status_word[3] rises on cycle 17; 15 cycles then 0 -> never rises.
//  Pulse err_parity+err_credit same cycle -> next cycle bits[5],[7]=1, err_cnt=2, status_changed next.
//  Inject 20 single error pulses -> err_cnt stops at 15; clear_req -> word[11:4]=0.
//  clear_req together with err_escape -> bit[6]=1, err_cnt=1.
//  Link up then link_state=2 -> link_up=0 next cycle, down_cnt=1; repeat 17x -> down_cnt=15.
//  With SPW_LINK_TC_CAPTURE_EN: tc_valid, tc_value=6'h2B -> word[15:12]=4'hB; clear_req keeps it.

Source files
------------

// File: rtl/spw_link_status_pkg.sv
// Shared definitions for the SpaceWire link status collector: link state
// encoding, status word layout and the debounce FSM state type.
package spw_link_status_pkg;

  typedef enum logic [2:0] {
    LS_ERROR_RESET = 3'd0,
    LS_ERROR_WAIT  = 3'd1,
    LS_READY       = 3'd2,
    LS_STARTED     = 3'd3,
    LS_CONNECTING  = 3'd4,
    LS_RUN         = 3'd5
  } link_state_e;

  localparam int LS_W       = 3;
  localparam int NUM_ERR    = 4;
  localparam int STATUS_W   = 16;
  localparam int FIELD_W    = 4;

  localparam int WB_LS      = 0;
  localparam int WB_LINK_UP = 3;
  localparam int WB_FLAGS   = 4;
  localparam int WB_ERR_CNT = 8;
  localparam int WB_UPPER   = 12;

  typedef enum logic [1:0] {
    DBNC_DOWN = 2'd0,
    DBNC_QUAL = 2'd1,
    DBNC_UP   = 2'd2
  } dbnc_state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/spw_sat_counter.sv
// Saturating up-counter with a multi-bit increment and a clear that is
// applied before the increment of the same cycle.
module spw_sat_counter #(
  parameter int W     = 4,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  localparam int SW = W + 1;

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] base;
  logic [W:0]   sum;

  always_comb begin
    base    = clear ? '0 : count_q;
    sum     = {1'b0, base} + SW'(inc);
    count_d = sum[W] ? '1 : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/spw_link_status_collector.sv
// Builds the 16-bit SpaceWire link status word for the status PIO.
// Optional feature: define SPW_LINK_TC_CAPTURE_EN to put the last time-code in [15:12].
module spw_link_status_collector
  import spw_link_status_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  link_state,
  input  logic        err_disconnect,
  input  logic        err_parity,
  input  logic        err_escape,
  input  logic        err_credit,
  input  logic        tc_valid,
  input  logic [5:0]  tc_value,
  input  logic        clear_req,
  output logic [15:0] status_word,
  output logic        status_changed
);

  localparam logic [8:0] DEB_TGT = 9'(DEBOUNCE_CYCLES);

  dbnc_state_e         state_q, state_d;
  logic [7:0]          qual_cnt_q, qual_cnt_d;
  logic [LS_W-1:0]     link_state_q, link_state_d;
  logic [NUM_ERR-1:0]  flags_q, flags_d;
  logic [STATUS_W-1:0] word_last_q, word_last_d;
  logic                status_changed_q, status_changed_d;
  logic [NUM_ERR-1:0]  err_vec;
  logic [CNT_W-1:0]    err_cnt;
  logic [CNT_W-1:0]    upper_field;
  logic                is_run;

  assign is_run  = (link_state == LS_RUN);
  assign err_vec = {err_credit, err_escape, err_parity, err_disconnect};

  // Debounce: link_up only after DEBOUNCE_CYCLES consecutive Run samples.
  always_comb begin
    state_d    = state_q;
    qual_cnt_d = qual_cnt_q;
    case (state_q)
      DBNC_DOWN: begin
        if (is_run) begin
          if (DEB_TGT <= 9'd1) begin
            state_d = DBNC_UP;
          end else begin
            state_d    = DBNC_QUAL;
            qual_cnt_d = 8'd1;
          end
        end
      end
      DBNC_QUAL: begin
        if (!is_run) begin
          state_d    = DBNC_DOWN;
          qual_cnt_d = 8'd0;
        end else if (({1'b0, qual_cnt_q} + 9'd1) >= DEB_TGT) begin
          state_d    = DBNC_UP;
          qual_cnt_d = 8'd0;
        end else begin
          qual_cnt_d = qual_cnt_q + 8'd1;
        end
      end
      DBNC_UP: begin
        if (!is_run) state_d = DBNC_DOWN;
      end
      default: begin
        state_d    = DBNC_DOWN;
        qual_cnt_d = 8'd0;
      end
    endcase
  end

  // Clear wins first, then this cycle's pulses are ORed back in.
  always_comb begin
    link_state_d = link_state;
    flags_d      = (clear_req ? '0 : flags_q) | err_vec;
  end

  spw_sat_counter #(.W(CNT_W), .INC_W(3)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_req),
    .inc     (popcount4(err_vec)),
    .count   (err_cnt)
  );

`ifdef SPW_LINK_TC_CAPTURE_EN
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             unused_tc_hi;

  assign unused_tc_hi = ^tc_value[5:4];

  always_comb begin
    tc_d = tc_valid ? tc_value[3:0] : tc_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) tc_q <= '0;
    else          tc_q <= tc_d;
  end

  assign upper_field = tc_q;
`else
  logic unused_tc;
  logic down_evt;

  assign unused_tc = ^{tc_valid, tc_value};
  assign down_evt  = (state_q == DBNC_UP) && !is_run;

  spw_sat_counter #(.W(CNT_W), .INC_W(1)) u_down_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_req),
    .inc     (down_evt),
    .count   (upper_field)
  );
`endif

  always_comb begin
    status_word                           = '0;
    status_word[WB_LS +: LS_W]            = link_state_q;
    status_word[WB_LINK_UP]               = (state_q == DBNC_UP);
    status_word[WB_FLAGS +: NUM_ERR]      = flags_q;
    status_word[WB_ERR_CNT +: FIELD_W]    = err_cnt;
    status_word[WB_UPPER +: FIELD_W]      = upper_field;
  end

  // Change strobe trails the word by one cycle: compare against last cycle's copy.
  always_comb begin
    word_last_d      = status_word;
    status_changed_d = (status_word != word_last_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= DBNC_DOWN;
      qual_cnt_q       <= '0;
      link_state_q     <= '0;
      flags_q          <= '0;
      word_last_q      <= '0;
      status_changed_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      qual_cnt_q       <= qual_cnt_d;
      link_state_q     <= link_state_d;
      flags_q          <= flags_d;
      word_last_q      <= word_last_d;
      status_changed_q <= status_changed_d;
    end
  end

  assign status_changed = status_changed_q;

endmodule

// File: tb/tb_spw_link_status_collector.sv
// Directed plus randomized bench for spw_link_status_collector against a
// streak/counter reference model; honours SPW_LINK_TC_CAPTURE_EN.
module tb_spw_link_status_collector;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  link_state = 3'd0;
  logic        err_disconnect = 1'b0;
  logic        err_parity = 1'b0;
  logic        err_escape = 1'b0;
  logic        err_credit = 1'b0;
  logic        tc_valid = 1'b0;
  logic [5:0]  tc_value = 6'd0;
  logic        clear_req = 1'b0;
  logic [15:0] status_word;
  logic        status_changed;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_streak = 0;
  int          m_errc = 0;
  int          m_downc = 0;
  logic        m_up = 1'b0;
  logic [3:0]  m_flags = 4'd0;
  logic [3:0]  m_tc = 4'd0;
  logic [2:0]  m_ls = 3'd0;
  logic [15:0] m_word = 16'd0;
  logic [15:0] m_last = 16'd0;
  logic        m_changed = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  spw_link_status_collector #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .link_state     (link_state),
    .err_disconnect (err_disconnect),
    .err_parity     (err_parity),
    .err_escape     (err_escape),
    .err_credit     (err_credit),
    .tc_valid       (tc_valid),
    .tc_value       (tc_value),
    .clear_req      (clear_req),
    .status_word    (status_word),
    .status_changed (status_changed)
  );

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic [15:0] model_word();
    logic [15:0] w;
    w        = 16'd0;
    w[2:0]   = m_ls;
    w[3]     = m_up;
    w[7:4]   = m_flags;
    w[11:8]  = 4'(m_errc);
`ifdef SPW_LINK_TC_CAPTURE_EN
    w[15:12] = m_tc;
`else
    w[15:12] = 4'(m_downc);
`endif
    return w;
  endfunction

  task automatic model_edge();
    logic prev_up;
    int   npulse;
    if (!reset_n) begin
      m_streak = 0; m_errc = 0; m_downc = 0; m_up = 1'b0;
      m_flags = 4'd0; m_tc = 4'd0; m_ls = 3'd0;
      m_word = 16'd0; m_last = 16'd0; m_changed = 1'b0;
    end else begin
      m_changed = (m_word != m_last);
      m_last    = m_word;
      if (clear_req) begin
        m_flags = 4'd0; m_errc = 0; m_downc = 0;
      end
      m_flags = m_flags | {err_credit, err_escape, err_parity, err_disconnect};
      npulse  = int'(err_credit) + int'(err_escape) + int'(err_parity) + int'(err_disconnect);
      m_errc  = sat15(m_errc + npulse);
      prev_up  = m_up;
      m_streak = (link_state == 3'd5) ? m_streak + 1 : 0;
      m_up     = (m_streak >= DEB);
      if (prev_up && !m_up) m_downc = sat15(m_downc + 1);
      if (tc_valid) m_tc = tc_value[3:0];
      m_ls   = link_state;
      m_word = model_word();
    end
    exp_q.push_back(m_word);
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later, pulses dropped.
  task automatic tick();
    logic [15:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    exp = exp_q.pop_front();
    check_val("word", status_word, exp);
    check_val("changed", 16'(status_changed), 16'(m_changed));
    err_disconnect = 1'b0; err_parity = 1'b0; err_escape = 1'b0; err_credit = 1'b0;
    clear_req = 1'b0; tc_valid = 1'b0;
  endtask

  initial begin
    // reset
    reset_n = 1'b0;
    repeat (3) tick();
    check_val("reset_word", status_word, 16'h0000);
    check_val("reset_changed", 16'(status_changed), 16'd0);
    reset_n = 1'b1;

    // debounce: 16 Run samples qualify
    link_state = 3'd5;
    repeat (15) tick();
    check_val("up_after15", 16'(status_word[3]), 16'd0);
    tick();
    check_val("up_after16", 16'(status_word[3]), 16'd1);
    link_state = 3'd2;
    tick();
    check_val("up_drop", 16'(status_word[3]), 16'd0);
`ifndef SPW_LINK_TC_CAPTURE_EN
    check_val("down_cnt_1", 16'(status_word[15:12]), 16'd1);
`endif

    // 15 Run samples then drop: never rises
    link_state = 3'd5;
    repeat (15) tick();
    link_state = 3'd0;
    tick();
    check_val("short_run_no_up", 16'(status_word[3]), 16'd0);

    // parity + credit together
    err_parity = 1'b1; err_credit = 1'b1;
    tick();
    check_val("pc_flags", 16'(status_word[7:4]), 16'h000A);
    check_val("pc_errcnt", 16'(status_word[11:8]), 16'd2);
    tick();
    check_val("pc_changed", 16'(status_changed), 16'd1);

    // 20 single pulses saturate err_cnt
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0: err_disconnect = 1'b1;
        1: err_parity     = 1'b1;
        2: err_escape     = 1'b1;
        default: err_credit = 1'b1;
      endcase
      tick();
    end
    check_val("errcnt_sat", 16'(status_word[11:8]), 16'd15);
    clear_req = 1'b1;
    tick();
    check_val("clear_11_4", 16'(status_word[11:4]), 16'd0);

    // clear with simultaneous escape
    clear_req = 1'b1; err_escape = 1'b1;
    tick();
    check_val("clr_esc_flags", 16'(status_word[7:4]), 16'h0004);
    check_val("clr_esc_cnt", 16'(status_word[11:8]), 16'd1);

`ifndef SPW_LINK_TC_CAPTURE_EN
    // 17 link up/down cycles saturate down_cnt
    clear_req = 1'b1;
    tick();
    for (int r = 0; r < 17; r++) begin
      link_state = 3'd5;
      repeat (16) tick();
      link_state = 3'd2;
      tick();
    end
    check_val("down_sat", 16'(status_word[15:12]), 16'd15);
    // clear in the same cycle as a link drop
    link_state = 3'd5;
    repeat (16) tick();
    link_state = 3'd2; clear_req = 1'b1;
    tick();
    check_val("clr_down_same", 16'(status_word[15:12]), 16'd1);
`else
    tc_valid = 1'b1; tc_value = 6'h2B;
    tick();
    check_val("tc_capture", 16'(status_word[15:12]), 16'h000B);
    clear_req = 1'b1;
    tick();
    check_val("tc_keep_clear", 16'(status_word[15:12]), 16'h000B);
`endif

    // reset during qualification restarts the count
    link_state = 3'd5;
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (15) tick();
    check_val("rst_qual_15", 16'(status_word[3]), 16'd0);
    tick();
    check_val("rst_qual_16", 16'(status_word[3]), 16'd1);

    // randomized traffic, states 6/7 included
    for (int i = 0; i < 800; i++) begin
      link_state     = ($urandom_range(0, 99) < 95) ? 3'd5 : 3'($urandom_range(0, 7));
      err_disconnect = ($urandom_range(0, 9) == 0);
      err_parity     = ($urandom_range(0, 9) == 0);
      err_escape     = ($urandom_range(0, 9) == 0);
      err_credit     = ($urandom_range(0, 9) == 0);
      clear_req      = ($urandom_range(0, 29) == 0);
      tc_valid       = ($urandom_range(0, 7) == 0);
      tc_value       = 6'($urandom_range(0, 63));
      reset_n        = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
